// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer sequencer: entry layout, FSM states and
// the note half-period table (clk cycles per half wave at 50 MHz).
package buzzer_pkg;

    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 7;
    localparam int LEN_MSB  = 6;
    localparam int LEN_LSB  = 0;
    localparam logic [11:0] END_MARKER = 12'h000;
    localparam int HALF_W   = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_PLAY
    } state_e;

    // Index 1 = C4, one semitone per step up to F#6; index 0 is the rest slot.
    localparam logic [HALF_W-1:0] NOTE_HALF [0:31] = '{
        17'd0,
        17'd95556, 17'd90194, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
        17'd67568, 17'd63776, 17'd60196, 17'd56818, 17'd53629, 17'd50619,
        17'd47778, 17'd45097, 17'd42566, 17'd40177, 17'd37922, 17'd35793,
        17'd33784, 17'd31888, 17'd30098, 17'd28409, 17'd26815, 17'd25310,
        17'd23889, 17'd22548, 17'd21283, 17'd20088, 17'd18961, 17'd17897,
        17'd16892
    };

    // Scaled half period, never below one cycle so the toggle always advances.
    function automatic logic [HALF_W-1:0] tone_half(input logic [4:0] idx,
                                                    input int unsigned shift);
        logic [HALF_W-1:0] h;
        h = NOTE_HALF[idx] >> shift;
        return (h == '0) ? HALF_W'(1) : h;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles every half_i cycles while enabled, starts
// low on each enable, and is forced low whenever disabled.
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int HW = HALF_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [HW-1:0] half_i,
    output logic          buzzer_o
);

    logic [HW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = '0;
        out_d = 1'b0;
        if (en_i) begin
            if (cnt_q == half_i - 1'b1) begin
                cnt_d = '0;
                out_d = ~out_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                out_d = out_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    // Gate so the level left over from the last play cycle never leaks out.
    assign buzzer_o = out_q & en_i;

endmodule

// File: rtl/buzzer_seq_ctrl.sv
// Song sequencer: fetches note entries from BRAM, decodes pitch/length and
// drives the tone generator for length x TICK_CYCLES clocks per entry.
module buzzer_seq_ctrl
    import buzzer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 12,
    parameter int TICK_CYCLES    = 3_125_000,
    parameter int TONE_DIV_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] song_base,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic                  buzzer_o,
    output logic [4:0]            note_o,
    output logic                  busy,
    output logic                  done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   entry_q, entry_d;
    logic [6:0]              len_q, len_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic                    done_q, done_d;
    logic [4:0]              ent_note;
    logic [6:0]              ent_len;
    logic                    tone_en;

    assign ent_note = entry_q[NOTE_MSB:NOTE_LSB];
    assign ent_len  = entry_q[LEN_MSB:LEN_LSB];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        entry_d = entry_q;
        len_d   = len_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = song_base;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                entry_d = bram_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (entry_q == END_MARKER) begin
                    if (loop_en) begin
                        ptr_d   = song_base;
                        state_d = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // A zero length only reaches here with a real note: play one tick.
                    len_d   = (ent_len == 7'd0) ? 7'd1 : ent_len;
                    tick_d  = '0;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (len_q == 7'd1) state_d = ST_FETCH;
                    else               len_d   = len_q - 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort has priority over everything, including a same-cycle start.
        if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            entry_q <= '0;
            len_q   <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            entry_q <= entry_d;
            len_q   <= len_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bram_en   = (state_q == ST_FETCH);
    assign bram_addr = ptr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign note_o    = (state_q == ST_PLAY) ? ent_note : 5'd0;
    assign tone_en   = (state_q == ST_PLAY) && (ent_note != 5'd0);

    buzzer_tone_gen #(.HW(HALF_W)) u_tone (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tone_en),
        .half_i   (tone_half(ent_note, TONE_DIV_SHIFT)),
        .buzzer_o (buzzer_o)
    );

endmodule

// File: tb/tb_buzzer_seq_ctrl.sv
// Bench for buzzer_seq_ctrl: a song model expands each start into a per-cycle
// expected trace; a monitor pops and compares one entry every cycle.
module tb_buzzer_seq_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 12;
    localparam int TICK  = 4;
    localparam int SHIFT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] song_base = '0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data = '0;
    logic          buzzer_o;
    logic [4:0]    note_o;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        bit          en;
        bit [AW-1:0] addr;
        bit [4:0]    note;
        bit          bz;
        bit          busy;
        bit          done;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   tests = 0;
    int   fails = 0;

    buzzer_seq_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TICK_CYCLES(TICK), .TONE_DIV_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .song_base(song_base), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_data(bram_data), .buzzer_o(buzzer_o), .note_o(note_o),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bram_en) bram_data <= mem[bram_addr];

    function automatic exp_t mk(bit en, bit [AW-1:0] a, bit [4:0] n, bit bz, bit b, bit d);
        exp_t x;
        x.en = en; x.addr = a; x.note = n; x.bz = bz; x.busy = b; x.done = d;
        return x;
    endfunction

    // Half period from equal temperament (C4 = 261.6 Hz, 50 MHz clock), then scaled.
    function automatic int half_of(input int idx);
        real f;
        int  h;
        if (idx == 0) return 1;
        f = 261.6256 * (2.0 ** ((idx - 1) / 12.0));
        h = int'(25.0e6 / f) >> SHIFT;
        return (h < 1) ? 1 : h;
    endfunction

    // Expected trace from the start cycle onward: fetch, wait, decode, then
    // length*TICK play cycles per entry; end marker finishes or restarts.
    function automatic void model_song(input bit [AW-1:0] base, input bit lp, input int passes);
        bit [AW-1:0] p;
        bit [11:0]   e;
        int          pass, len, h;
        p = base;
        pass = 0;
        q.push_back(mk(0, 0, 0, 0, 0, 0));
        while (1) begin
            q.push_back(mk(1, p, 0, 0, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 1, 0));
            e = mem[p];
            q.push_back(mk(0, 0, 0, 0, 1, 0));
            if (e == 12'h000) begin
                if (!lp) begin
                    q.push_back(mk(0, 0, 0, 0, 0, 1));
                    break;
                end
                pass++;
                if (pass >= passes) break;
                p = base;
                continue;
            end
            len = (e[6:0] == 0) ? 1 : int'(e[6:0]);
            h   = half_of(int'(e[11:7]));
            p   = p + 1'b1;
            for (int k = 0; k < len * TICK; k++)
                q.push_back(mk(0, 0, e[11:7], (e[11:7] != 0) && (((k / h) % 2) == 1), 1, 0));
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) mon_x = q.pop_front();
        else              mon_x = mk(0, 0, 0, 0, 0, 0);
        tests++;
        if (bram_en !== mon_x.en || (mon_x.en && bram_addr !== mon_x.addr) ||
            note_o !== mon_x.note || buzzer_o !== mon_x.bz ||
            busy !== mon_x.busy || done !== mon_x.done) begin
            fails++;
            $display("FAIL trace @%0t: got en=%b addr=%h note=%0d bz=%b busy=%b done=%b, want en=%b addr=%h note=%0d bz=%b busy=%b done=%b",
                     $time, bram_en, bram_addr, note_o, buzzer_o, busy, done,
                     mon_x.en, mon_x.addr, mon_x.note, mon_x.bz, mon_x.busy, mon_x.done);
        end
    end

    task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // All driver tasks are entered and left at posedge+1.
    task automatic start_song(input bit [AW-1:0] base, input bit lp, input int passes);
        song_base = base;
        loop_en   = lp;
        start     = 1'b1;
        model_song(base, lp, passes);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue_stop(input bit with_start);
        start = with_start;
        stop  = 1'b1;
        while (q.size() > 1) void'(q.pop_back());
        @(posedge clk); #1;
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_q(input int target, input int budget, input string nm);
        int n = 0;
        while (q.size() != target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (q.size() != target) begin
            fails++;
            $display("FAIL %s timeout: queue %0d want %0d", nm, q.size(), target);
            q.delete();
        end
    endtask

    task automatic wait_play(input int budget, input string nm);
        int n = 0;
        while (!(q.size() > 0 && q[0].note != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!(q.size() > 0 && q[0].note != 0)) begin
            fails++;
            $display("FAIL %s: no sounding note within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        bit [AW-1:0] b;
        bit [11:0]   e;
        int          n;
        foreach (mem[i]) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bram_en, bram_addr, note_o, buzzer_o, busy, done}, 20'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single note then end marker.
        mem[11'h010] = 12'h083; mem[11'h011] = 12'h000;
        start_song(11'h010, 0, 1);
        wait_q(0, 500, "basic");

        // Rest entry followed by a note.
        mem[11'h020] = 12'h002; mem[11'h021] = 12'h083; mem[11'h022] = 12'h000;
        start_song(11'h020, 0, 1);
        wait_q(0, 500, "rest");

        // Pointer wraps from the top of the address space to zero.
        mem[11'h7FF] = 12'h101; mem[11'h000] = 12'h000;
        start_song(11'h7FF, 0, 1);
        wait_q(0, 500, "wrap");

        // Looping song: three passes, then abort on the last end-marker decode.
        mem[11'h100] = 12'h182; mem[11'h101] = 12'h200; mem[11'h102] = 12'h000;
        start_song(11'h100, 1, 3);
        wait_q(1, 1000, "loop");
        issue_stop(0);
        loop_en = 1'b0;
        wait_q(0, 10, "loop_end");

        // Stop+start together mid-note, then a clean restart.
        start_song(11'h010, 0, 1);
        wait_play(50, "stopstart_play");
        repeat (2) @(posedge clk);
        #1;
        issue_stop(1);
        repeat (3) @(posedge clk);
        #1;
        start_song(11'h010, 0, 1);
        wait_q(0, 500, "restart1");

        // Plain stop mid-note.
        start_song(11'h020, 0, 1);
        wait_play(80, "stop_play");
        issue_stop(0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a sounding note.
        start_song(11'h010, 0, 1);
        wait_play(50, "rst_play");
        #2 rst = 1'b1;
        q.delete();
        #1 chk("rst_midplay", {bram_en, bram_addr, note_o, buzzer_o, busy, done}, 20'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_song(11'h010, 0, 1);
        wait_q(0, 500, "restart2");

        // Randomized songs with stray starts and occasional aborts.
        for (int s = 0; s < 30; s++) begin
            b = AW'($urandom_range(0, (1 << AW) - 1));
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                e = {5'($urandom_range(0, 31)), 7'($urandom_range(0, 5))};
                if (e == 12'h000) e = 12'h080;
                mem[b + AW'(i)] = e;
            end
            mem[b + AW'(n)] = 12'h000;
            start_song(b, 0, 1);
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
            if (q.size() > 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if ($urandom_range(0, 3) == 0 && q.size() > 1) issue_stop(0);
            wait_q(0, 1000, "random");
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
